// File: rtl/alu_operand_stage_if.sv
// Register-file bus and ALU operand handshake bundle for alu_operand_stage.
// The master side drives the buses and consumes operands; the slave side is the stage itself.
interface alu_operand_stage_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned NIB = WIDTH / 4;

    logic [WIDTH-1:0] abus_n;
    logic [WIDTH-1:0] bbus_n;
    logic             bus_valid;
    logic             bus_ready;
    logic             precharge;
    logic             clr_op2;
    logic [NIB-1:0]   nib_mask;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] DV;
    logic             op_valid;
    logic             op_ready;

    modport master (
        output abus_n, bbus_n, bus_valid, clr_op2, nib_mask, op_ready,
        input  bus_ready, precharge, alu, DV, op_valid
    );

    modport slave (
        input  abus_n, bbus_n, bus_valid, clr_op2, nib_mask, op_ready,
        output bus_ready, precharge, alu, DV, op_valid
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: precharge/sample/hold sequencing of the active-low abus/bbus pair,
// operand latching with per-nibble Operand2 masking, and registered per-nibble DAA hints.
module alu_operand_stage #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned NIB   = WIDTH / 4
) (
    input  logic                CLK,
    input  logic                RES,
    alu_operand_stage_if.slave  bus,
    input  logic [WIDTH-1:0]    Aout,
    output logic [NIB-1:0]      nib_gt9,
    output logic [NIB-1:0]      nib_b30
);

    typedef enum logic [1:0] {
        ST_PRE    = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             capture_c;
    logic [WIDTH-1:0] op2_c;
    logic [NIB-1:0]   gt9_c;
    logic [NIB-1:0]   b30_c;

    // Operand2 gating and DAA hint decode, one nibble at a time
    for (genvar k = 0; k < NIB; k++) begin : g_nib
        assign op2_c[4*k +: 4] = ~bus.bbus_n[4*k +: 4] & {4{~(bus.clr_op2 | bus.nib_mask[k])}};
        assign gt9_c[k]        = Aout[4*k+3] & (Aout[4*k+1] | Aout[4*k+2]);
        assign b30_c[k]        = Aout[4*k+3] & Aout[4*k];
    end

    // Next-state decode; bus_valid only matters in SAMPLE, op_ready only in HOLD
    always_comb begin
        state_nx  = state;
        capture_c = 1'b0;
        case (state)
            ST_PRE: begin
                state_nx = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.bus_valid) begin
                    state_nx  = ST_HOLD;
                    capture_c = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.op_ready) begin
                    state_nx = ST_PRE;
                end
            end
            default: begin
                state_nx = ST_PRE;
            end
        endcase
    end

    // State register with handshake outputs registered from the next state
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state         <= ST_PRE;
            bus.precharge <= 1'b1;
            bus.bus_ready <= 1'b0;
            bus.op_valid  <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.precharge <= (state_nx == ST_PRE);
            bus.bus_ready <= (state_nx == ST_SAMPLE);
            bus.op_valid  <= (state_nx == ST_HOLD);
        end
    end

    // Operand keepers: only a SAMPLE-state capture edge changes them
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            bus.alu <= '0;
            bus.DV  <= '0;
        end else if (capture_c) begin
            bus.alu <= ~bus.abus_n;
            bus.DV  <= op2_c;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            nib_gt9 <= '0;
            nib_b30 <= '0;
        end else begin
            nib_gt9 <= gt9_c;
            nib_b30 <= b30_c;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage at WIDTH=8 and WIDTH=16.
module tb_alu_operand_stage;

    logic        CLK;
    logic        RES;
    logic [7:0]  aout8;
    logic [15:0] aout16;
    logic [1:0]  gt9_8, b30_8;
    logic [3:0]  gt9_16, b30_16;

    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_stage_if #(.WIDTH(8))  if8 ();
    alu_operand_stage_if #(.WIDTH(16)) if16 ();

    alu_operand_stage #(.WIDTH(8)) dut8 (
        .CLK     (CLK),
        .RES     (RES),
        .bus     (if8.slave),
        .Aout    (aout8),
        .nib_gt9 (gt9_8),
        .nib_b30 (b30_8)
    );

    alu_operand_stage #(.WIDTH(16)) dut16 (
        .CLK     (CLK),
        .RES     (RES),
        .bus     (if16.slave),
        .Aout    (aout16),
        .nib_gt9 (gt9_16),
        .nib_b30 (b30_16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RES = 1'b1;
        if8.abus_n = '1;  if8.bbus_n = '1;  if8.bus_valid = 1'b0;  if8.op_ready = 1'b0;
        if8.clr_op2 = 1'b0;  if8.nib_mask = '0;
        if16.abus_n = '1; if16.bbus_n = '1; if16.bus_valid = 1'b0; if16.op_ready = 1'b0;
        if16.clr_op2 = 1'b0; if16.nib_mask = '0;
        aout8 = 8'h00;
        aout16 = 16'h0000;
        step(); step();
        n_checks++; if (if8.precharge !== 1'b1) begin n_fail++; $display("FAIL reset_precharge got %b exp 1", if8.precharge); end
        n_checks++; if (if8.bus_ready !== 1'b0) begin n_fail++; $display("FAIL reset_bus_ready got %b exp 0", if8.bus_ready); end
        n_checks++; if (if8.op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got %b exp 0", if8.op_valid); end
        n_checks++; if ({if8.alu, if8.DV} !== 16'h0000) begin n_fail++; $display("FAIL reset_operands got %h exp 0000", {if8.alu, if8.DV}); end
        RES = 1'b0;
        // cycle 0 after release: still PRE
        n_checks++; if (if8.precharge !== 1'b1) begin n_fail++; $display("FAIL release_c0_precharge got %b exp 1", if8.precharge); end
        step();
        n_checks++; if (if8.bus_ready !== 1'b1 || if8.precharge !== 1'b0) begin n_fail++; $display("FAIL release_c1_sample got rdy=%b pre=%b exp rdy=1 pre=0", if8.bus_ready, if8.precharge); end
        n_checks++; if (if8.op_valid !== 1'b0 || if8.alu !== 8'h00 || if8.DV !== 8'h00) begin n_fail++; $display("FAIL release_c1_operands got v=%b alu=%h dv=%h exp 0/00/00", if8.op_valid, if8.alu, if8.DV); end
        n_checks++; if (if16.bus_ready !== 1'b1) begin n_fail++; $display("FAIL release_w16_sample got %b exp 1", if16.bus_ready); end
    endtask

    task automatic test_capture();
        if8.abus_n = 8'hC3; if8.bbus_n = 8'h0F; if8.bus_valid = 1'b1;
        step();
        if8.bus_valid = 1'b0;
        n_checks++; if (if8.alu !== 8'h3C) begin n_fail++; $display("FAIL capture_alu got %h exp 3c", if8.alu); end
        n_checks++; if (if8.DV !== 8'hF0) begin n_fail++; $display("FAIL capture_dv got %h exp f0", if8.DV); end
        n_checks++; if (if8.op_valid !== 1'b1 || if8.bus_ready !== 1'b0) begin n_fail++; $display("FAIL capture_hs got v=%b rdy=%b exp 1/0", if8.op_valid, if8.bus_ready); end
        if8.abus_n = 8'h00; if8.bbus_n = 8'h00;
        step(); step();
        n_checks++; if (if8.op_valid !== 1'b1 || if8.alu !== 8'h3C || if8.DV !== 8'hF0) begin n_fail++; $display("FAIL hold_stable got v=%b alu=%h dv=%h exp 1/3c/f0", if8.op_valid, if8.alu, if8.DV); end
        if8.op_ready = 1'b1;
        step();
        if8.op_ready = 1'b0;
        n_checks++; if (if8.op_valid !== 1'b0 || if8.precharge !== 1'b1 || if8.bus_ready !== 1'b0) begin n_fail++; $display("FAIL consume_pre got v=%b pre=%b rdy=%b exp 0/1/0", if8.op_valid, if8.precharge, if8.bus_ready); end
        n_checks++; if (if8.alu !== 8'h3C) begin n_fail++; $display("FAIL consume_keep_alu got %h exp 3c", if8.alu); end
        step();
        n_checks++; if (if8.bus_ready !== 1'b1 || if8.precharge !== 1'b0) begin n_fail++; $display("FAIL pre_to_sample got rdy=%b pre=%b exp 1/0", if8.bus_ready, if8.precharge); end
    endtask

    task automatic test_mask();
        if8.abus_n = 8'hFF; if8.bbus_n = 8'h00; if8.nib_mask = 2'b10; if8.bus_valid = 1'b1;
        step();
        if8.bus_valid = 1'b0;
        n_checks++; if (if8.DV !== 8'h0F || if8.alu !== 8'h00) begin n_fail++; $display("FAIL mask_hi got dv=%h alu=%h exp 0f/00", if8.DV, if8.alu); end
        if8.nib_mask = 2'b11; if8.clr_op2 = 1'b1;
        step();
        n_checks++; if (if8.DV !== 8'h0F) begin n_fail++; $display("FAIL mask_change_in_hold got %h exp 0f", if8.DV); end
        if8.op_ready = 1'b1; step();
        if8.op_ready = 1'b0; if8.clr_op2 = 1'b0; if8.nib_mask = 2'b00; step();
        if8.clr_op2 = 1'b1; if8.nib_mask = 2'b01; if8.bus_valid = 1'b1;
        step();
        if8.bus_valid = 1'b0; if8.clr_op2 = 1'b0; if8.nib_mask = 2'b00;
        n_checks++; if (if8.DV !== 8'h00 || if8.op_valid !== 1'b1) begin n_fail++; $display("FAIL clr_op2 got dv=%h v=%b exp 00/1", if8.DV, if8.op_valid); end
        if8.op_ready = 1'b1; step();
        if8.op_ready = 1'b0; step();
    endtask

    task automatic test_daa();
        aout8 = 8'h9A; aout16 = 16'h8A9F;
        step();
        n_checks++; if (gt9_8 !== 2'b01 || b30_8 !== 2'b10) begin n_fail++; $display("FAIL daa_9a got gt9=%b b30=%b exp 01/10", gt9_8, b30_8); end
        n_checks++; if (gt9_16 !== 4'b0101 || b30_16 !== 4'b0011) begin n_fail++; $display("FAIL daa_w16 got gt9=%b b30=%b exp 0101/0011", gt9_16, b30_16); end
        aout8 = 8'h99;
        step();
        n_checks++; if (gt9_8 !== 2'b00 || b30_8 !== 2'b11) begin n_fail++; $display("FAIL daa_99 got gt9=%b b30=%b exp 00/11", gt9_8, b30_8); end
        aout8 = 8'hF0;
        step();
        n_checks++; if (gt9_8 !== 2'b10 || b30_8 !== 2'b10) begin n_fail++; $display("FAIL daa_f0 got gt9=%b b30=%b exp 10/10", gt9_8, b30_8); end
        aout8 = 8'h00; aout16 = 16'h0000;
        step();
    endtask

    task automatic test_back_to_back();
        int   captures;
        logic prev;
        captures = 0;
        prev = if16.op_valid;
        if16.abus_n = 16'h1234; if16.bbus_n = 16'h00FF; if16.nib_mask = 4'b0100;
        if16.bus_valid = 1'b1; if16.op_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (if16.op_valid === 1'b1 && prev !== 1'b1) captures++;
            prev = if16.op_valid;
        end
        if16.bus_valid = 1'b0; if16.op_ready = 1'b0;
        n_checks++; if (captures !== 3) begin n_fail++; $display("FAIL b2b_captures got %0d exp 3", captures); end
        n_checks++; if (if16.alu !== 16'hEDCB || if16.DV !== 16'hF000) begin n_fail++; $display("FAIL b2b_operands got alu=%h dv=%h exp edcb/f000", if16.alu, if16.DV); end
        n_checks++; if (if16.bus_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end_state got rdy=%b exp 1", if16.bus_ready); end
    endtask

    task automatic test_hold_ignore();
        if16.bus_valid = 1'b1;
        step();
        if16.bus_valid = 1'b0;
        if16.abus_n = 16'h0000; if16.bbus_n = 16'h0000; if16.nib_mask = 4'b0000;
        if16.bus_valid = 1'b1;
        step();
        if16.bus_valid = 1'b0;
        n_checks++; if (if16.op_valid !== 1'b1 || if16.bus_ready !== 1'b0) begin n_fail++; $display("FAIL hold_pulse_hs got v=%b rdy=%b exp 1/0", if16.op_valid, if16.bus_ready); end
        n_checks++; if (if16.alu !== 16'hEDCB || if16.DV !== 16'hF000) begin n_fail++; $display("FAIL hold_pulse_ops got alu=%h dv=%h exp edcb/f000", if16.alu, if16.DV); end
        if16.op_ready = 1'b1; if16.bus_valid = 1'b1;
        step();
        if16.op_ready = 1'b0; if16.bus_valid = 1'b0;
        n_checks++; if (if16.op_valid !== 1'b0 || if16.precharge !== 1'b1 || if16.alu !== 16'hEDCB) begin n_fail++; $display("FAIL ready_and_valid got v=%b pre=%b alu=%h exp 0/1/edcb", if16.op_valid, if16.precharge, if16.alu); end
        step();
        n_checks++; if (if16.bus_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ignore_resample got %b exp 1", if16.bus_ready); end
    endtask

    task automatic test_async_reset();
        if8.abus_n = 8'h5A; if8.bbus_n = 8'hA5; aout8 = 8'hFF; if8.bus_valid = 1'b1;
        step();
        if8.bus_valid = 1'b0;
        step();
        n_checks++; if (if8.alu !== 8'hA5 || if8.DV !== 8'h5A || gt9_8 !== 2'b11 || b30_8 !== 2'b11) begin n_fail++; $display("FAIL pre_async_state got alu=%h dv=%h gt9=%b b30=%b exp a5/5a/11/11", if8.alu, if8.DV, gt9_8, b30_8); end
        #2;
        RES = 1'b1;
        #1;
        n_checks++; if (if8.op_valid !== 1'b0 || if8.alu !== 8'h00 || if8.DV !== 8'h00) begin n_fail++; $display("FAIL async_ops got v=%b alu=%h dv=%h exp 0/00/00", if8.op_valid, if8.alu, if8.DV); end
        n_checks++; if (gt9_8 !== 2'b00 || b30_8 !== 2'b00 || if8.precharge !== 1'b1) begin n_fail++; $display("FAIL async_flags got gt9=%b b30=%b pre=%b exp 00/00/1", gt9_8, b30_8, if8.precharge); end
        aout8 = 8'h00;
        step();
        RES = 1'b0;
        n_checks++; if (if8.precharge !== 1'b1 || if8.bus_ready !== 1'b0) begin n_fail++; $display("FAIL async_release_pre got pre=%b rdy=%b exp 1/0", if8.precharge, if8.bus_ready); end
        step();
        n_checks++; if (if8.bus_ready !== 1'b1 || if8.op_valid !== 1'b0) begin n_fail++; $display("FAIL async_release_sample got rdy=%b v=%b exp 1/0", if8.bus_ready, if8.op_valid); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_mask();
        test_daa();
        test_back_to_back();
        test_hold_ignore();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
